// File: rtl/mpc_types_pkg.sv
//------------------------------------------------------------------------------
// Module : mpc_types (package)
// Brief  : Shared state encoding, defaults and width helpers for the victim
//          way scheduler.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mpc_types;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOOKUP  = 2'd1,
        EVAL    = 2'd2,
        BACKOFF = 2'd3
    } vic_state_e;

    localparam int c_cnt_w_default   = 3;
    localparam int c_req_num_default = 2;
    localparam int c_way_num_default = 4;

    // Index width that stays at least one bit wide for single-entry vectors.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Increment modulo n; legal for non-power-of-2 n.
    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

    localparam int c_req_idx_w_default = idx_width(c_req_num_default);
    localparam int c_way_idx_w_default = idx_width(c_way_num_default);

endpackage

`default_nettype wire

// File: rtl/mpc_rr_pick.sv
//------------------------------------------------------------------------------
// Module : mpc_rr_pick
// Brief  : Combinational rotating priority picker: first set bit at or after
//          a start pointer, wrapping modulo N.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mpc_rr_pick
    import mpc_types::*;
#(
    parameter int N  = 2,
    parameter int PW = idx_width(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic          o_found,
    output logic [PW-1:0] o_idx
);

    function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] p, input int off);
        int s;
        s = int'(p) + off;
        if (s >= N) s = s - N;
        return PW'(s);
    endfunction

    // Scan from farthest to nearest so the nearest hit is the final assignment.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[wrap_idx(i_ptr, i)]) begin
                o_found = 1'b1;
                o_idx   = wrap_idx(i_ptr, i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/victim_way_sched.sv
//------------------------------------------------------------------------------
// Module : victim_way_sched
// Brief  : Round-robin victim-way scheduler for line allocation; optional
//          stall counter enabled by MPC_VICTIM_STALL_CNT_EN.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module victim_way_sched
    import mpc_types::*;
#(
    parameter int REQ_NUM    = 2,
    parameter int WAY_NUM    = 4,
    parameter int SET_WIDTH  = 6,
    parameter int CNT_W      = c_cnt_w_default,
    parameter int RETRY_WAIT = 4,
    parameter int REQ_IDX_W  = idx_width(REQ_NUM),
    parameter int WAY_IDX_W  = idx_width(WAY_NUM)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [REQ_NUM-1:0]           req_valid,
    input  logic [REQ_NUM*SET_WIDTH-1:0] req_set,
    output logic [REQ_NUM-1:0]           req_ready,
    output logic [SET_WIDTH-1:0]         ref_cnt_set,
    input  logic [WAY_NUM*CNT_W-1:0]     ref_cnt_rsp,
    input  logic                         ref_cnt_access_valid,
    input  logic [SET_WIDTH-1:0]         ref_cnt_access_set,
    input  logic [WAY_IDX_W-1:0]         ref_cnt_access_way,
    output logic                         vic_valid,
    output logic [REQ_IDX_W-1:0]         vic_id,
    output logic [SET_WIDTH-1:0]         vic_set,
    output logic [WAY_IDX_W-1:0]         vic_way,
    output logic                         busy
`ifdef MPC_VICTIM_STALL_CNT_EN
    ,
    input  logic                         stall_cnt_clr,
    output logic [15:0]                  stall_cnt
`endif
);

    localparam int c_retry_w = idx_width(RETRY_WAIT);

    vic_state_e             r_state;
    vic_state_e             w_state_nxt;
    logic [REQ_IDX_W-1:0]   r_req_ptr;
    logic [WAY_IDX_W-1:0]   r_way_ptr;
    logic [REQ_IDX_W-1:0]   r_id;
    logic [SET_WIDTH-1:0]   r_set;
    logic [WAY_NUM-1:0]     r_mask;
    logic [c_retry_w-1:0]   r_retry;

    logic [WAY_NUM-1:0]     w_hit;
    logic [WAY_NUM-1:0]     w_free;
    logic                   w_req_found;
    logic [REQ_IDX_W-1:0]   w_req_idx;
    logic                   w_way_found;
    logic [WAY_IDX_W-1:0]   w_way_idx;
    logic                   w_grant;
    logic                   w_vic;
    logic                   w_stall;

    // Hazard hits are live snoops; EVAL ORs them with the mask captured in LOOKUP.
    generate
        for (genvar w = 0; w < WAY_NUM; w++) begin : g_hit
            assign w_hit[w]  = ref_cnt_access_valid
                               && (ref_cnt_access_set == r_set)
                               && (ref_cnt_access_way == WAY_IDX_W'(w));
            assign w_free[w] = (ref_cnt_rsp[w*CNT_W +: CNT_W] == '0)
                               && !(r_mask[w] || w_hit[w]);
        end
    endgenerate

    mpc_rr_pick #(.N(REQ_NUM), .PW(REQ_IDX_W)) u_req_pick (
        .i_req   (req_valid),
        .i_ptr   (r_req_ptr),
        .o_found (w_req_found),
        .o_idx   (w_req_idx)
    );

    mpc_rr_pick #(.N(WAY_NUM), .PW(WAY_IDX_W)) u_way_pick (
        .i_req   (w_free),
        .i_ptr   (r_way_ptr),
        .o_found (w_way_found),
        .o_idx   (w_way_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_vic       = 1'b0;
        w_stall     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req_found) begin
                    w_grant     = 1'b1;
                    w_state_nxt = LOOKUP;
                end
            end
            LOOKUP: w_state_nxt = EVAL;
            EVAL: begin
                if (w_way_found) begin
                    w_vic       = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_stall     = 1'b1;
                    w_state_nxt = BACKOFF;
                end
            end
            BACKOFF: begin
                if (r_retry == '0) w_state_nxt = LOOKUP;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_ptr <= '0;
            r_way_ptr <= '0;
            r_id      <= '0;
            r_set     <= '0;
            r_mask    <= '0;
            r_retry   <= '0;
        end else begin
            if (w_grant) begin
                r_id      <= w_req_idx;
                r_set     <= req_set[int'(w_req_idx)*SET_WIDTH +: SET_WIDTH];
                r_req_ptr <= REQ_IDX_W'(wrap_inc(int'(w_req_idx), REQ_NUM));
            end
            if (r_state == LOOKUP) r_mask <= w_hit;
            if (w_vic) begin
                r_way_ptr <= WAY_IDX_W'(wrap_inc(int'(w_way_idx), WAY_NUM));
                r_id      <= '0;
                r_set     <= '0;
            end
            if (w_stall)
                r_retry <= c_retry_w'(RETRY_WAIT - 1);
            else if ((r_state == BACKOFF) && (r_retry != '0))
                r_retry <= r_retry - 1'b1;
        end
    end

    // Ready is qualified by rst_n so every output is low for the whole reset.
    generate
        for (genvar r = 0; r < REQ_NUM; r++) begin : g_ready
            assign req_ready[r] = w_grant && rst_n && (w_req_idx == REQ_IDX_W'(r));
        end
    endgenerate

    assign ref_cnt_set = r_set;
    assign vic_valid   = w_vic;
    assign vic_id      = w_vic ? r_id      : '0;
    assign vic_set     = w_vic ? r_set     : '0;
    assign vic_way     = w_vic ? w_way_idx : '0;
    assign busy        = (r_state != IDLE);

`ifdef MPC_VICTIM_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_stall_cnt <= '0;
        else if (stall_cnt_clr)
            r_stall_cnt <= '0;
        else if (w_stall && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_victim_way_sched.sv
//------------------------------------------------------------------------------
// Module : tb_victim_way_sched
// Brief  : Self-checking bench for victim_way_sched with a timeline model.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_victim_way_sched;

    localparam int REQ_NUM    = 2;
    localparam int WAY_NUM    = 4;
    localparam int SET_WIDTH  = 6;
    localparam int CNT_W      = 3;
    localparam int RETRY_WAIT = 4;

    logic                         clk = 1'b0;
    logic                         rst_n = 1'b1;
    logic [REQ_NUM-1:0]           req_valid = '0;
    logic [REQ_NUM*SET_WIDTH-1:0] req_set = '0;
    logic [REQ_NUM-1:0]           req_ready;
    logic [SET_WIDTH-1:0]         ref_cnt_set;
    logic [WAY_NUM*CNT_W-1:0]     ref_cnt_rsp = '0;
    logic                         ref_cnt_access_valid = 1'b0;
    logic [SET_WIDTH-1:0]         ref_cnt_access_set = '0;
    logic [1:0]                   ref_cnt_access_way = '0;
    logic                         vic_valid;
    logic [0:0]                   vic_id;
    logic [SET_WIDTH-1:0]         vic_set;
    logic [1:0]                   vic_way;
    logic                         busy;
`ifdef MPC_VICTIM_STALL_CNT_EN
    logic                         stall_cnt_clr = 1'b0;
    logic [15:0]                  stall_cnt;
`endif

    victim_way_sched #(
        .REQ_NUM(REQ_NUM), .WAY_NUM(WAY_NUM), .SET_WIDTH(SET_WIDTH),
        .CNT_W(CNT_W), .RETRY_WAIT(RETRY_WAIT)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .req_valid            (req_valid),
        .req_set              (req_set),
        .req_ready            (req_ready),
        .ref_cnt_set          (ref_cnt_set),
        .ref_cnt_rsp          (ref_cnt_rsp),
        .ref_cnt_access_valid (ref_cnt_access_valid),
        .ref_cnt_access_set   (ref_cnt_access_set),
        .ref_cnt_access_way   (ref_cnt_access_way),
        .vic_valid            (vic_valid),
        .vic_id               (vic_id),
        .vic_set              (vic_set),
        .vic_way              (vic_way),
        .busy                 (busy)
`ifdef MPC_VICTIM_STALL_CNT_EN
        ,
        .stall_cnt_clr        (stall_cnt_clr),
        .stall_cnt            (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference-count memory with a one-cycle registered read.
    logic [WAY_NUM*CNT_W-1:0] cnt_mem [64];
    always @(posedge clk) ref_cnt_rsp <= cnt_mem[ref_cnt_set];

    typedef struct {
        int cyc;
        int id;
        int set;
        int way;
    } ev_t;

    ev_t gq[$];
    ev_t vq[$];
    int  rcs_log[int];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Timeline model: a grant at cycle G is evaluated at G+2, each retry +RETRY_WAIT+2.
    bit                 m_busy;
    int                 m_eval, m_id, m_set, m_rptr, m_wptr, m_stall;
    logic [WAY_NUM-1:0] m_lookup_hits;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_eval = 0; m_id = 0; m_set = 0;
        m_rptr = 0; m_wptr = 0; m_stall = 0; m_lookup_hits = '0;
    endtask

    task automatic model_step();
        logic [REQ_NUM-1:0] e_ready;
        logic [WAY_NUM-1:0] hits;
        logic [WAY_NUM-1:0] free;
        bit e_vic;
        int e_way;
        int win;
        int k;
        for (int w = 0; w < WAY_NUM; w++)
            hits[w] = ref_cnt_access_valid && (int'(ref_cnt_access_set) == m_set)
                      && (int'(ref_cnt_access_way) == w);
        e_ready = '0;
        win = -1;
        if (!m_busy) begin
            for (int i = 0; i < REQ_NUM; i++) begin
                k = (m_rptr + i) % REQ_NUM;
                if (win < 0 && req_valid[k]) win = k;
            end
            if (win >= 0) e_ready[win] = 1'b1;
        end
        e_vic = 0;
        e_way = 0;
        if (m_busy && cyc == m_eval) begin
            for (int w = 0; w < WAY_NUM; w++)
                free[w] = (ref_cnt_rsp[w*CNT_W +: CNT_W] == 0) && !(m_lookup_hits[w] || hits[w]);
            for (int i = 0; i < WAY_NUM; i++) begin
                k = (m_wptr + i) % WAY_NUM;
                if (!e_vic && free[k]) begin
                    e_vic = 1;
                    e_way = k;
                end
            end
        end

        chk("req_ready", 32'(req_ready), 32'(e_ready));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("ref_cnt_set", 32'(ref_cnt_set), m_busy ? m_set : 0);
        chk("vic_valid", 32'(vic_valid), 32'(e_vic));
        if (e_vic) begin
            chk("vic_id", 32'(vic_id), m_id);
            chk("vic_set", 32'(vic_set), m_set);
            chk("vic_way", 32'(vic_way), e_way);
        end
`ifdef MPC_VICTIM_STALL_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), m_stall);
        if (stall_cnt_clr) m_stall = 0;
        else if (m_busy && cyc == m_eval && !e_vic && m_stall < 65535) m_stall++;
`endif

        if (m_busy && cyc == m_eval - 1) m_lookup_hits = hits;
        if (m_busy && cyc == m_eval) begin
            if (e_vic) begin
                m_busy = 0;
                m_wptr = (e_way + 1) % WAY_NUM;
            end else begin
                m_eval = m_eval + RETRY_WAIT + 2;
            end
        end else if (!m_busy && win >= 0) begin
            m_busy = 1;
            m_eval = cyc + 2;
            m_id   = win;
            m_set  = int'(req_set[win*SET_WIDTH +: SET_WIDTH]);
            m_rptr = (win + 1) % REQ_NUM;
        end
    endtask

    task automatic log_outputs();
        ev_t e;
        rcs_log[cyc] = int'(ref_cnt_set);
        for (int i = 0; i < REQ_NUM; i++) begin
            if (req_ready[i]) begin
                e = '{cyc, i, int'(req_set[i*SET_WIDTH +: SET_WIDTH]), 0};
                gq.push_back(e);
            end
        end
        if (vic_valid) begin
            e = '{cyc, int'(vic_id), int'(vic_set), int'(vic_way)};
            vq.push_back(e);
        end
    endtask

    // Evaluate the current cycle at the falling edge, then step past the next rising edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            model_reset();
        end else begin
            log_outputs();
            model_step();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grants(input int n, input int budget);
        int t = 0;
        while (gq.size() < n && t < budget) begin
            tick();
            t++;
        end
        chk("grant_timeout", 32'(gq.size() >= n), 1);
    endtask

    task automatic wait_vics(input int n, input int budget);
        int t = 0;
        while (vq.size() < n && t < budget) begin
            tick();
            t++;
        end
        chk("vic_timeout", 32'(vq.size() >= n), 1);
    endtask

    initial begin
        int gb;
        int vb;
        for (int s = 0; s < 64; s++) cnt_mem[s] = {WAY_NUM{3'd1}};
        model_reset();
        #1 rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // Single request: only way0 has a zero count.
        cnt_mem[5] = {3'd3, 3'd1, 3'd2, 3'd0};
        req_set    = {6'd0, 6'd5};
        req_valid  = 2'b01;
        wait_grants(1, 10);
        req_valid  = 2'b00;
        wait_vics(1, 10);
        chk("t1_grant_id", gq[0].id, 0);
        chk("t1_lookup_set", rcs_log[gq[0].cyc + 1], 5);
        chk("t1_latency", vq[0].cyc - gq[0].cyc, 2);
        chk("t1_way", vq[0].way, 0);
        chk("t1_id", vq[0].id, 0);
        chk("t1_set", vq[0].set, 5);

        // Way pointer moved to 1.
        cnt_mem[7] = '0;
        req_set    = {6'd0, 6'd7};
        req_valid  = 2'b01;
        wait_grants(2, 10);
        req_valid  = 2'b00;
        wait_vics(2, 10);
        chk("t1b_way", vq[1].way, 1);
        chk("t1b_id", vq[1].id, 0);

        // Round-robin fairness from a fresh reset.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        gb = gq.size();
        vb = vq.size();
        cnt_mem[9] = '0;
        req_set    = {6'd9, 6'd9};
        req_valid  = 2'b11;
        wait_vics(vb + 5, 40);
        req_valid  = 2'b00;
        for (int i = 0; i < 5; i++) begin
            chk("t2_grant_id", gq[gb+i].id, i % 2);
            chk("t2_way", vq[vb+i].way, i % 4);
        end
        for (int i = 0; i < 4; i++)
            chk("t2_spacing", gq[gb+i+1].cyc - gq[gb+i].cyc, 3);

        // Hazard on the only free way during LOOKUP forces one back-off.
        cnt_mem[5] = {3'd1, 3'd0, 3'd1, 3'd1};
        req_set    = {6'd5, 6'd0};
        req_valid  = 2'b10;
        gb = gq.size();
        vb = vq.size();
        wait_grants(gb + 1, 10);
        req_valid            = 2'b00;
        ref_cnt_access_valid = 1'b1;
        ref_cnt_access_set   = 6'd5;
        ref_cnt_access_way   = 2'd2;
        tick();
        ref_cnt_access_valid = 1'b0;
        wait_vics(vb + 1, 30);
        chk("t3_latency", vq[vb].cyc - gq[gb].cyc, 8);
        chk("t3_way", vq[vb].way, 2);
        chk("t3_id", vq[vb].id, 1);

        // All ways referenced for three lookups, way3 frees before the fourth.
`ifdef MPC_VICTIM_STALL_CNT_EN
        stall_cnt_clr = 1'b1;
        tick();
        stall_cnt_clr = 1'b0;
`endif
        req_set   = {6'd0, 6'd11};
        req_valid = 2'b01;
        gb = gq.size();
        vb = vq.size();
        wait_grants(gb + 1, 10);
        req_valid = 2'b00;
        repeat (15) tick();
        cnt_mem[11] = {3'd0, 3'd1, 3'd1, 3'd1};
        wait_vics(vb + 1, 20);
        chk("t4_latency", vq[vb].cyc - gq[gb].cyc, 20);
        chk("t4_way", vq[vb].way, 3);
`ifdef MPC_VICTIM_STALL_CNT_EN
        chk("t4_stall_cnt", 32'(stall_cnt), 3);
`endif

        // Asynchronous reset while backing off.
        cnt_mem[13] = {WAY_NUM{3'd1}};
        req_set     = {6'd13, 6'd13};
        req_valid   = 2'b11;
        gb = gq.size();
        wait_grants(gb + 1, 10);
        chk("t5_first_grant_id", gq[gb].id, 1);
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_ref_cnt_set", 32'(ref_cnt_set), 0);
        chk("t5_rst_vic_valid", 32'(vic_valid), 0);
        chk("t5_rst_req_ready", 32'(req_ready), 0);
        vb = vq.size();
        tick();
        tick();
        #1 rst_n = 1'b1;
        wait_grants(gb + 2, 5);
        chk("t5_regrant_id", gq[gb+1].id, 0);
        chk("t5_no_vic", vq.size(), vb);
        req_valid   = 2'b00;
        cnt_mem[13] = '0;
        wait_vics(vb + 1, 10);
        chk("t5_way", vq[vb].way, 0);
        chk("t5_id", vq[vb].id, 0);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
